dac_spi_scheduler: RTL

DAC_SPI_SCHEDULER -- requirements
Module: dac_spi_scheduler

---
 rtl/dac_spi_pkg.sv | 16 +
 rtl/dac_spi_shifter.sv | 60 ++++++
 rtl/dac_spi_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared types and constants for the dual-DAC SPI scheduler.
// Holds the scheduler state enum and the serial frame geometry.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } state_e;

  localparam int FRAME_BITS = 24;
  localparam int HALF_BITS  = 48;
  localparam int CNT_W      = $clog2(FRAME_BITS);

endpackage

// File: rtl/dac_spi_shifter.sv
// dac_spi_shifter: 24-bit MSB-first serializer, two clocks per bit.
// Ports: clk_i/rst_i, load_i+data_i (load word), active_i (shift enable),
// sclk_o/din_o (serial lines, 0 when idle), done_o (last half-bit cycle).
import dac_spi_pkg::*;

module dac_spi_shifter #(
  parameter logic [7:0] CTRL_BYTE = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] data_i,
  input  logic        active_i,
  output logic        sclk_o,
  output logic        din_o,
  output logic        done_o
);

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic                  ph_q, ph_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last;

  // ph_q = 0: SCLK high half; ph_q = 1: SCLK low half
  assign last = ph_q && (cnt_q == CNT_W'(FRAME_BITS - 1));

  always_comb begin
    sr_d  = sr_q;
    ph_d  = ph_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = {CTRL_BYTE, data_i};
      ph_d  = 1'b0;
      cnt_d = '0;
    end else if (active_i) begin
      ph_d = ~ph_q;
      if (ph_q) begin
        sr_d  = {sr_q[FRAME_BITS-2:0], 1'b0};
        cnt_d = last ? '0 : cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      ph_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
    end
  end

  assign sclk_o = active_i & ~ph_q;
  assign din_o  = active_i & sr_q[FRAME_BITS-1];
  assign done_o = active_i & last;

endmodule

// File: rtl/dac_spi_scheduler.sv
// dac_spi_scheduler: time-shares one serializer between two DACs.
// Ports: dataclk/reset, sample_strobe+DAC_en+DAC_register_1/2 (frame request),
// overrun_clr; DAC_SYNC/DAC_SCLK/DAC_DIN (SPI), busy, frame_done, overrun.
import dac_spi_pkg::*;

module dac_spi_scheduler #(
  parameter logic [7:0]  CTRL_BYTE = 8'h00,
  parameter int unsigned SYNC_GAP  = 2
) (
  input  logic        dataclk,
  input  logic        reset,
  input  logic        sample_strobe,
  input  logic [1:0]  DAC_en,
  input  logic [15:0] DAC_register_1,
  input  logic [15:0] DAC_register_2,
  input  logic        overrun_clr,
  output logic [1:0]  DAC_SYNC,
  output logic        DAC_SCLK,
  output logic        DAC_DIN,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int GAP_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;

  state_e      state_q, state_d;
  logic        chan_q, chan_d;
  logic [1:0]  en_q, en_d;
  logic [15:0] r1_q, r1_d;
  logic [15:0] r2_q, r2_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic        ovr_q, ovr_d;

  logic        load;
  logic [15:0] ld_data;
  logic        bit_done;
  logic        active;

  assign active = (state_q == SHIFT);
  assign busy   = (state_q == SHIFT) || (state_q == GAP);

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    en_d    = en_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    gap_d   = gap_q;
    load    = 1'b0;
    ld_data = r2_q;
    unique case (state_q)
      // DONE accepts a strobe just like IDLE
      IDLE, DONE: begin
        state_d = IDLE;
        if (sample_strobe) begin
          en_d = DAC_en;
          r1_d = DAC_register_1;
          r2_d = DAC_register_2;
          if (DAC_en[0]) begin
            state_d = SHIFT;
            chan_d  = 1'b0;
            load    = 1'b1;
            ld_data = DAC_register_1;
          end else if (DAC_en[1]) begin
            state_d = SHIFT;
            chan_d  = 1'b1;
            load    = 1'b1;
            ld_data = DAC_register_2;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        if (bit_done) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_W'(SYNC_GAP - 1)) begin
          if (!chan_q && en_q[1]) begin
            state_d = SHIFT;
            chan_d  = 1'b1;
            load    = 1'b1;
            ld_data = r2_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a rejected strobe beats a simultaneous clear
  always_comb begin
    ovr_d = ovr_q;
    if (sample_strobe && busy) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge dataclk) begin
    if (reset) begin
      state_q <= IDLE;
      chan_q  <= 1'b0;
      en_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      gap_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      en_q    <= en_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      gap_q   <= gap_d;
      ovr_q   <= ovr_d;
    end
  end

  dac_spi_shifter #(
    .CTRL_BYTE(CTRL_BYTE)
  ) u_shifter (
    .clk_i   (dataclk),
    .rst_i   (reset),
    .load_i  (load),
    .data_i  (ld_data),
    .active_i(active),
    .sclk_o  (DAC_SCLK),
    .din_o   (DAC_DIN),
    .done_o  (bit_done)
  );

  assign DAC_SYNC   = active ? (chan_q ? 2'b01 : 2'b10) : 2'b11;
  assign frame_done = (state_q == DONE);
  assign overrun    = ovr_q;

endmodule
